// File: rtl/mem_stall_ctrl_if.sv
// mem_stall_ctrl_if: MEM-stage decode inputs, slave acknowledges and stall-control outputs.
interface mem_stall_ctrl_if #(parameter int NUM_CS = 4);
    localparam int IW = $clog2(NUM_CS);
    logic              rden;
    logic              wren;
    logic [NUM_CS-1:0] cs;
    logic [NUM_CS-1:0] ack;
    logic              pc_wren;
    logic              mem_ctrl_mux;
    logic              reg_ctrl_mux;
    logic              req_start;
    logic              bus_err;
    logic [IW-1:0]     sel_idx;
    modport master(
        input  rden, wren, cs, ack,
        output pc_wren, mem_ctrl_mux, reg_ctrl_mux, req_start, sel_idx, bus_err
    );
    modport slave(
        output rden, wren, cs, ack,
        input  pc_wren, mem_ctrl_mux, reg_ctrl_mux, req_start, sel_idx, bus_err
    );
endinterface

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: freezes PC/pipeline while a MEM access waits on a handshaked region,
// with wait timeout (bus_err) and a saturating stall-cycle counter.
module mem_stall_ctrl #(
    parameter int                NUM_CS         = 4,
    parameter logic [NUM_CS-1:0] STALL_MASK     = NUM_CS'(1),
    parameter int                TO_W           = 8,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter int                CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rstn,
    mem_stall_ctrl_if.master  bus,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int IW = $clog2(NUM_CS);
    typedef enum logic [1:0] {PROCESS, STALL, ERROR} state_t;
    state_t            state, nxt;
    logic [NUM_CS-1:0] hit;
    logic              stall_cond, acked, timeout, pc_wren;
    logic [IW-1:0]     p, sel_idx;
    logic [TO_W-1:0]   wait_cnt;
    assign hit        = bus.cs & STALL_MASK;
    assign stall_cond = (bus.rden | bus.wren) & |hit;
    // only the latched region's acknowledge can release the stall
    assign acked      = bus.ack[sel_idx];
    assign timeout    = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign bus.sel_idx = sel_idx;
    always_comb begin
        p = '0;
        for (int i = NUM_CS - 1; i >= 0; i--)
            if (hit[i]) p = IW'(i);
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= PROCESS;
        else       state <= nxt;
    always_comb
        nxt = state == PROCESS ? (stall_cond ? STALL : PROCESS) :
              state == STALL   ? (acked ? PROCESS : timeout ? ERROR : STALL) : PROCESS;
    always_comb begin
        pc_wren          = state == PROCESS ? !stall_cond : state == STALL ? acked : 1'b1;
        bus.pc_wren      = pc_wren;
        bus.reg_ctrl_mux = !pc_wren;
        bus.mem_ctrl_mux = state != PROCESS;
        bus.req_start    = state == PROCESS && stall_cond;
        bus.bus_err      = state == ERROR;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            sel_idx  <= '0;
            wait_cnt <= '0;
        end else if (state == PROCESS && stall_cond) begin
            sel_idx  <= p;
            wait_cnt <= '0;
        end else if (state == STALL && !acked && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)                         stall_cnt <= '0;
        else if (stat_clr)                 stall_cnt <= '0;
        else if (!pc_wren && ~&stall_cnt)  stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed stimulus with a per-cycle rule model plus literal checks.
module tb_mem_stall_ctrl;
    localparam int         NUM_CS = 4;
    localparam logic [3:0] MASK   = 4'b0101;
    localparam int         TO     = 5;
    localparam int         CMAX   = 15;

    logic       clk = 0;
    logic       rstn;
    logic       stat_clr;
    logic [3:0] stall_cnt;
    int         checks = 0, errors = 0;
    int         lowcnt, reqcnt, errcnt;
    int         rgn, waited, esel, cnt;
    logic       errc;

    mem_stall_ctrl_if #(.NUM_CS(NUM_CS)) bus();

    mem_stall_ctrl #(
        .NUM_CS(NUM_CS), .STALL_MASK(MASK), .TO_W(8), .TIMEOUT_CYCLES(TO), .CNT_W(4)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .stat_clr(stat_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
        end
    endtask

    // rule model: outputs follow from where the access stands (idle / waiting on a region / error)
    always @(negedge clk) begin
        logic e_pc, e_mem, e_reg, e_req, e_err;
        int   p;
        if (!rstn) begin
            rgn = -1; waited = 0; errc = 0; cnt = 0; esel = 0;
        end
        e_pc = 1; e_mem = 0; e_reg = 0; e_req = 0; e_err = 0; p = -1;
        if (errc) begin
            e_mem = 1; e_err = 1;
        end else if (rgn >= 0) begin
            e_mem = 1;
            if (bus.ack[rgn]) e_pc = 1;
            else begin e_pc = 0; e_reg = 1; end
        end else begin
            for (int i = NUM_CS - 1; i >= 0; i--)
                if (bus.cs[i] && MASK[i] && (bus.rden || bus.wren)) p = i;
            if (p >= 0) begin e_pc = 0; e_reg = 1; e_req = 1; end
        end
        chk("pc_wren", bus.pc_wren, e_pc);
        chk("mem_ctrl_mux", bus.mem_ctrl_mux, e_mem);
        chk("reg_ctrl_mux", bus.reg_ctrl_mux, e_reg);
        chk("req_start", bus.req_start, e_req);
        chk("bus_err", bus.bus_err, e_err);
        chk("sel_idx", bus.sel_idx, esel);
        chk("stall_cnt", stall_cnt, cnt);
        if (rstn) begin
            if (!bus.pc_wren) lowcnt++;
            if (bus.req_start) reqcnt++;
            if (bus.bus_err) errcnt++;
            if (errc) errc = 0;
            else if (rgn >= 0) begin
                if (bus.ack[rgn]) rgn = -1;
                else if (waited == TO - 1) begin rgn = -1; errc = 1; end
                else waited++;
            end else if (p >= 0) begin
                rgn = p; waited = 0; esel = p;
            end
            cnt = stat_clr ? 0 : (!e_pc && cnt < CMAX) ? cnt + 1 : cnt;
        end
    end

    task automatic clr_counts();
        lowcnt = 0; reqcnt = 0; errcnt = 0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [3:0] c,
                          input int d, input logic [3:0] pre, input logic [3:0] fin);
        @(posedge clk); #1 bus.rden = rd; bus.wren = wr; bus.cs = c;
        @(posedge clk); #1 bus.rden = 0; bus.wren = 0; bus.cs = 0; bus.ack = pre;
        repeat (d) @(posedge clk);
        #1 bus.ack = fin;
        @(posedge clk); #1 bus.ack = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 0; stat_clr = 0;
        bus.rden = 0; bus.wren = 0; bus.cs = 0; bus.ack = 0;
        clr_counts();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_pc_wren", bus.pc_wren, 1);
        chk("reset_mem_mux", bus.mem_ctrl_mux, 0);

        clr_counts();
        access(1, 0, 4'b0001, 3, 4'b0000, 4'b0001);
        chk("load_low_cycles", lowcnt, 4);
        chk("load_req_pulses", reqcnt, 1);
        chk("load_stall_cnt", stall_cnt, 4);
        chk("load_sel_idx", bus.sel_idx, 0);

        clr_counts();
        @(posedge clk); #1 bus.wren = 1; bus.cs = 4'b0010;
        repeat (2) @(posedge clk);
        #1 bus.wren = 0; bus.cs = 0;
        chk("zero_wait_low", lowcnt, 0);

        clr_counts();
        access(0, 1, 4'b0001, 3, 4'b0010, 4'b0001);
        chk("foreign_ack_low", lowcnt, 4);
        chk("foreign_ack_cnt", stall_cnt, 8);

        clr_counts();
        access(1, 0, 4'b0001, 8, 4'b0000, 4'b0000);
        chk("timeout_low", lowcnt, 6);
        chk("timeout_err", errcnt, 1);
        chk("timeout_cnt", stall_cnt, 14);

        clr_counts();
        access(1, 0, 4'b0001, 4, 4'b0000, 4'b0001);
        chk("ack_at_timeout_low", lowcnt, 5);
        chk("ack_at_timeout_err", errcnt, 0);
        chk("saturate_cnt", stall_cnt, 15);

        @(posedge clk); #1 bus.rden = 1; bus.cs = 4'b0100;
        @(posedge clk); #1 bus.rden = 0; bus.cs = 0;
        @(posedge clk); #1 stat_clr = 1;
        @(posedge clk); #1 stat_clr = 0;
        chk("clr_cnt", stall_cnt, 0);
        chk("clr_sel_idx", bus.sel_idx, 2);
        @(posedge clk); #1 bus.ack = 4'b0100;
        @(posedge clk); #1 bus.ack = 0;
        chk("after_clr_cnt", stall_cnt, 1);

        clr_counts();
        @(posedge clk); #1 bus.rden = 1; bus.cs = 4'b0001;
        @(posedge clk); #1 bus.rden = 0; bus.cs = 0;
        @(posedge clk); #1 rstn = 0;
        #1;
        chk("rst_mid_pc", bus.pc_wren, 1);
        chk("rst_mid_mem", bus.mem_ctrl_mux, 0);
        chk("rst_mid_err", bus.bus_err, 0);
        chk("rst_mid_cnt", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_err", errcnt, 0);

        clr_counts();
        @(posedge clk); #1 bus.rden = 1; bus.cs = 4'b0001; bus.ack = 4'b0001;
        repeat (6) @(posedge clk);
        #1 bus.rden = 0; bus.cs = 0; bus.ack = 0;
        chk("b2b_low", lowcnt, 3);
        chk("b2b_req", reqcnt, 3);
        chk("b2b_cnt", stall_cnt, 3);

        clr_counts();
        access(1, 0, 4'b1101, 2, 4'b0100, 4'b0001);
        chk("prio_low", lowcnt, 3);
        chk("prio_sel_idx", bus.sel_idx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Parametrised memory-stage stall controller for the 5-stage pipeline. It freezes the PC and pipeline registers while a load or store targets a slow, handshaked slave region, and releases them on that slave's acknowledge. It supports NUM_CS chip-select regions, a per-region zero-wait/handshake mask, a wait timeout that raises a bus error, and a stall-cycle performance counter. It sits between MEM-stage decode (rden/wren/chip selects) and the PC / pipeline-register write enables and mux selects.

## Interface
Parameters:
- NUM_CS, 4: number of chip-select regions, >= 2.
- STALL_MASK, 4'b0001 (NUM_CS bits): bit i = 1 means region i is handshaked (stalls until ack); 0 means zero-wait.
- TO_W, 8: width of the wait-timeout counter.
- TIMEOUT_CYCLES, 255: stall cycles before timeout; 0 disables timeout. Must fit in TO_W bits.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- rden  in  1  MEM-stage load.
- wren  in  1  MEM-stage store.
- cs  in  NUM_CS  region chip selects, normally one-hot.
- ack  in  NUM_CS  per-region completion acknowledge.
- stat_clr  in  1  synchronous clear of stall_cnt.
- pc_wren  out  1  PC / pipeline-register write enable.
- mem_ctrl_mux  out  1  1 = hold memory control signals at their stalled values.
- reg_ctrl_mux  out  1  1 = inject bubble / hold register-write controls.
- req_start  out  1  one-cycle pulse on the cycle a stall begins.
- sel_idx  out  $clog2(NUM_CS)  latched index of the region being waited on.
- bus_err  out  1  one-cycle timeout error pulse.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_wren = 0.

## Operation
- Stall condition: stall_cond = (rden | wren) & |(cs & STALL_MASK). Priority index p is the lowest i with cs[i] & STALL_MASK[i]. Zero-wait regions never stall.
- States: PROCESS, STALL, ERROR.
- PROCESS:
  - mem_ctrl_mux = 0, bus_err = 0.
  - If stall_cond: pc_wren = 0, reg_ctrl_mux = 1, req_start = 1. On the clock: sel_idx <= p, wait_cnt <= 0, go to STALL.
  - Else: pc_wren = 1, reg_ctrl_mux = 0, req_start = 0.
- STALL:
  - mem_ctrl_mux = 1, req_start = 0. Only ack[sel_idx] is honoured; other ack bits are ignored.
  - If ack[sel_idx]: pc_wren = 1, reg_ctrl_mux = 0, go to PROCESS.
  - Else if TIMEOUT_CYCLES != 0 and wait_cnt == TIMEOUT_CYCLES-1: pc_wren = 0, reg_ctrl_mux = 1, go to ERROR.
  - Else: pc_wren = 0, reg_ctrl_mux = 1, wait_cnt++.
  - If ack and timeout coincide, ack wins.
- ERROR (exactly one cycle): mem_ctrl_mux = 1, pc_wren = 1, reg_ctrl_mux = 0, bus_err = 1. Next state is PROCESS.
- stall_cnt:
  - Increments each cycle pc_wren = 0 and saturates at all-ones.
  - stat_clr sets it to 0 and takes priority over a same-cycle increment.
- Outputs pc_wren, reg_ctrl_mux, mem_ctrl_mux, req_start and bus_err are Mealy/combinational from state and inputs, as above. sel_idx and stall_cnt are registered.

## Timing
- Reset (async assert, sync use on release): state = PROCESS, sel_idx = 0, wait_cnt = 0, stall_cnt = 0.
- With rden = wren = 0 after reset: pc_wren = 1, reg_ctrl_mux = 0, mem_ctrl_mux = 0, req_start = 0, bus_err = 0.
- Reset asserted mid-STALL or in ERROR returns to PROCESS immediately. No bus_err is emitted.
- A stall lasts N+1 cycles with pc_wren = 0 when ack arrives N cycles after entering STALL (ack on the first STALL cycle gives a 1-cycle stall).
- Timeout path: 1 PROCESS cycle + TIMEOUT_CYCLES STALL cycles with pc_wren = 0, then 1 ERROR cycle with pc_wren = 1.
- Back-to-back accesses: after release, a new stall_cond in the next PROCESS cycle stalls again immediately. There are no forced idle cycles.
- The cs/rden/wren inputs are not re-evaluated while in STALL. Changes to them during STALL do not alter sel_idx.

## Test plan
- Reset, then idle inputs -> pc_wren = 1, all other outputs 0, stall_cnt = 0.
- rden = 1, cs = 4'b0001, ack[0] rises 3 cycles after entry -> req_start pulses once, pc_wren = 0 for 4 cycles, sel_idx = 0, stall_cnt = 4, return to PROCESS.
- wren = 1, cs = 4'b0010 (masked zero-wait) -> no stall, pc_wren stays 1. Then cs = 4'b0001 with ack = 4'b0010 only -> remains stalled and ignores the foreign ack.
- TIMEOUT_CYCLES = 5, no ack -> pc_wren = 0 for 6 cycles, then bus_err = 1 and pc_wren = 1 for one cycle, then PROCESS.
- Ack on the same cycle as timeout -> clean release, bus_err stays 0. Separately: rstn low mid-STALL -> outputs at reset values, no bus_err.
- stall_cnt preset near all-ones via a long stall with CNT_W = 4 -> saturates at 15. stat_clr during a stall -> reads 0 the next cycle.
